// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared definitions for the CORDIC round-robin scheduler.
//   id_bits()  : number of requester-id bits carried in the CORDIC code field
//   slice_lo() : low bit of element idx inside a packed per-requester vector
//   ret_kind_t : classification of a result returning from the CORDIC
// Code field layout: requester id in code[id_bits-1:0], all higher bits are
// reserved and driven 0 on issue; a returning code with any of them set is bad.
package cordic_rr_scheduler_pkg;

    function automatic int id_bits(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    typedef enum logic [1:0] {
        RET_NONE     = 2'd0,
        RET_PUSH     = 2'd1,
        RET_BAD_ID   = 2'd2,
        RET_OVERFLOW = 2'd3
    } ret_kind_t;

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Issue/return bus between the scheduler and the shared pipelined CORDIC.
//   master : scheduler side (drives issue, receives results)
//   slave  : CORDIC side (receives issue, drives results)
interface cordic_rr_scheduler_if #(
    parameter int WIDTH      = 16,
    parameter int CODE_WIDTH = 8
);
    logic                   cordic_valid;
    logic signed [WIDTH-1:0] cordic_x;
    logic signed [WIDTH-1:0] cordic_y;
    logic signed [WIDTH-1:0] cordic_angle;
    logic [CODE_WIDTH-1:0]  cordic_code;
    logic                   cordic_res_valid;
    logic signed [WIDTH-1:0] cordic_res_x;
    logic signed [WIDTH-1:0] cordic_res_y;
    logic [CODE_WIDTH-1:0]  cordic_res_code;

    modport master (
        output cordic_valid, cordic_x, cordic_y, cordic_angle, cordic_code,
        input  cordic_res_valid, cordic_res_x, cordic_res_y, cordic_res_code
    );

    modport slave (
        input  cordic_valid, cordic_x, cordic_y, cordic_angle, cordic_code,
        output cordic_res_valid, cordic_res_x, cordic_res_y, cordic_res_code
    );
endinterface

// File: rtl/cordic_rr_scheduler_res.sv
// cordic_res_fifo: single-clock result FIFO, registered storage.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   push/push_data : write request (honoured when not full, or full with pop)
//   pop            : read request (ignored when empty)
//   head           : head entry, 0 while empty
//   full, empty    : status
module cordic_res_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: shares one pipelined CORDIC between N_REQ requesters.
//   clock, reset_n            : rising-edge clock, asynchronous active-low reset
//   enable                    : 0 blocks new grants; in-flight results still drain
//   req_valid/req_ready       : per-requester request handshake (ready is one-hot or 0)
//   req_x/req_y/req_angle     : packed operands, requester r at [r*WIDTH +: WIDTH]
//   cordic (master)           : registered issue to the CORDIC, raw results back
//   res_valid/res_ready       : per-requester result FIFO handshake
//   res_x/res_y               : packed head-of-FIFO results
//   err_bad_id, err_overflow  : sticky error flags, cleared only by reset
module cordic_rr_scheduler
    import cordic_rr_scheduler_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 16,
    parameter int CODE_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_x,
    input  logic [N_REQ*WIDTH-1:0]   req_y,
    input  logic [N_REQ*WIDTH-1:0]   req_angle,
    cordic_rr_scheduler_if.master    cordic,
    output logic [N_REQ-1:0]         res_valid,
    input  logic [N_REQ-1:0]         res_ready,
    output logic [N_REQ*WIDTH-1:0]   res_x,
    output logic [N_REQ*WIDTH-1:0]   res_y,
    output logic                     err_bad_id,
    output logic                     err_overflow
);
    localparam int ID_BITS = id_bits(N_REQ);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ID_BITS-1:0]      ptr;
    logic [ID_BITS-1:0]      grant_idx;
    logic [N_REQ-1:0]        eligible;
    logic [N_REQ-1:0]        grant;
    logic                    accept;
    logic [N_REQ-1:0]        pop;
    logic [N_REQ-1:0]        push;
    logic [N_REQ-1:0]        full;
    logic [CNT_W-1:0]        outstanding [N_REQ];
    logic [ID_BITS-1:0]      ret_id;
    ret_kind_t               ret_kind;
    logic [2*WIDTH-1:0]      ret_data;

    logic                    vld_p1;
    logic signed [WIDTH-1:0] x_p1;
    logic signed [WIDTH-1:0] y_p1;
    logic signed [WIDTH-1:0] angle_p1;
    logic [CODE_WIDTH-1:0]   code_p1;

    // reset_n gates eligibility so no ready is shown while reset is held.
    always_comb begin
        for (int r = 0; r < N_REQ; r++) begin
            eligible[r] = reset_n && enable && req_valid[r] &&
                          (outstanding[r] < CNT_W'(DEPTH));
        end
    end

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int  cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && eligible[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = ID_BITS'(cand);
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;

    // ---- stage p1: registered issue to the CORDIC ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            x_p1     <= '0;
            y_p1     <= '0;
            angle_p1 <= '0;
            code_p1  <= '0;
            ptr      <= ID_BITS'(N_REQ - 1);
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                x_p1     <= signed'(req_x[slice_lo(int'(grant_idx), WIDTH) +: WIDTH]);
                y_p1     <= signed'(req_y[slice_lo(int'(grant_idx), WIDTH) +: WIDTH]);
                angle_p1 <= signed'(req_angle[slice_lo(int'(grant_idx), WIDTH) +: WIDTH]);
                code_p1  <= CODE_WIDTH'(grant_idx);
                ptr      <= grant_idx;
            end
        end
    end

    assign cordic.cordic_valid = vld_p1;
    assign cordic.cordic_x     = x_p1;
    assign cordic.cordic_y     = y_p1;
    assign cordic.cordic_angle = angle_p1;
    assign cordic.cordic_code  = code_p1;

    // Credits: accept and pop in the same cycle cancel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < N_REQ; r++) outstanding[r] <= '0;
        end else begin
            for (int r = 0; r < N_REQ; r++) begin
                case ({grant[r], pop[r]})
                    2'b10:   outstanding[r] <= outstanding[r] + 1'b1;
                    2'b01:   outstanding[r] <= outstanding[r] - 1'b1;
                    default: outstanding[r] <= outstanding[r];
                endcase
            end
        end
    end

    // Return path steering; reserved code bits or an out-of-range id are bad.
    assign ret_id   = cordic.cordic_res_code[ID_BITS-1:0];
    assign ret_data = {cordic.cordic_res_x, cordic.cordic_res_y};

    always_comb begin
        ret_kind = RET_NONE;
        push     = '0;
        if (cordic.cordic_res_valid) begin
            if (((cordic.cordic_res_code >> ID_BITS) != '0) ||
                ({1'b0, ret_id} >= (ID_BITS + 1)'(N_REQ))) begin
                ret_kind = RET_BAD_ID;
            end else if (full[ret_id] && !pop[ret_id]) begin
                ret_kind = RET_OVERFLOW;
            end else begin
                ret_kind     = RET_PUSH;
                push[ret_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_bad_id   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (ret_kind == RET_BAD_ID)   err_bad_id   <= 1'b1;
            if (ret_kind == RET_OVERFLOW) err_overflow <= 1'b1;
        end
    end

    // ---- stage p2: per-requester result FIFOs ----
    for (genvar r = 0; r < N_REQ; r++) begin : g_fifo
        logic [2*WIDTH-1:0] head;
        logic               empty;

        cordic_res_fifo #(
            .DATA_W (2 * WIDTH),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (push[r]),
            .push_data (ret_data),
            .pop       (pop[r]),
            .head      (head),
            .full      (full[r]),
            .empty     (empty)
        );

        assign res_valid[r] = !empty;
        assign pop[r]       = res_valid[r] && res_ready[r];
        assign res_x[slice_lo(r, WIDTH) +: WIDTH] = head[2*WIDTH-1:WIDTH];
        assign res_y[slice_lo(r, WIDTH) +: WIDTH] = head[WIDTH-1:0];
    end
endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler. The CORDIC is replaced by a
// fixed-latency stand-in (13 register stages, as for STAGES=12) returning
// x_out = x_in and y_out = y_in + angle_in with the code passed through.
// An injection mux lets the bench force arbitrary results onto the return bus.
module tb_cordic_rr_scheduler;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int CW  = 8;
    localparam int LAT = 13;

    logic            clock;
    logic            reset_n;
    logic            enable;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_x;
    logic [N*W-1:0]  req_y;
    logic [N*W-1:0]  req_angle;
    logic [N-1:0]    res_valid;
    logic [N-1:0]    res_ready;
    logic [N*W-1:0]  res_x;
    logic [N*W-1:0]  res_y;
    logic            err_bad_id;
    logic            err_overflow;

    logic            inj_en;
    logic [CW-1:0]   inj_code;
    logic [W-1:0]    inj_x;
    logic [W-1:0]    inj_y;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt [N];
    int pop_cnt [N];

    cordic_rr_scheduler_if #(.WIDTH(W), .CODE_WIDTH(CW)) cif ();

    cordic_rr_scheduler #(.N_REQ(N), .WIDTH(W), .CODE_WIDTH(CW), .DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_angle    (req_angle),
        .cordic       (cif),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_x        (res_x),
        .res_y        (res_y),
        .err_bad_id   (err_bad_id),
        .err_overflow (err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fixed-latency CORDIC stand-in, reset from reset_n like the real parent.
    logic [LAT-1:0] pv;
    logic [W-1:0]   px [LAT];
    logic [W-1:0]   py [LAT];
    logic [CW-1:0]  pc [LAT];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], cif.cordic_valid};
            px[0] <= cif.cordic_x;
            py[0] <= cif.cordic_y + cif.cordic_angle;
            pc[0] <= cif.cordic_code;
            for (int i = 1; i < LAT; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    assign cif.cordic_res_valid = inj_en ? 1'b1     : pv[LAT-1];
    assign cif.cordic_res_x     = inj_en ? inj_x    : px[LAT-1];
    assign cif.cordic_res_y     = inj_en ? inj_y    : py[LAT-1];
    assign cif.cordic_res_code  = inj_en ? inj_code : pc[LAT-1];

    // Handshake counters sampled on the active edge.
    always @(posedge clock) begin
        if (reset_n) begin
            for (int r = 0; r < N; r++) begin
                if (req_valid[r] && req_ready[r]) acc_cnt[r] <= acc_cnt[r] + 1;
                if (res_valid[r] && res_ready[r]) pop_cnt[r] <= pop_cnt[r] + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] a);
        req_x[r*W +: W]     = x;
        req_y[r*W +: W]     = y;
        req_angle[r*W +: W] = a;
    endtask

    function automatic int pop_total();
        int s = 0;
        for (int r = 0; r < N; r++) s += pop_cnt[r];
        return s;
    endfunction

    initial begin
        int   exp_id;
        int   snap0;
        int   snap1;
        logic early;
        logic stale;
        int   r0_seen;

        for (int r = 0; r < N; r++) begin
            acc_cnt[r] = 0;
            pop_cnt[r] = 0;
        end
        reset_n   = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        res_ready = '0;
        req_x     = '0;
        req_y     = '0;
        req_angle = '0;
        inj_en    = 1'b0;
        inj_code  = '0;
        inj_x     = '0;
        inj_y     = '0;

        // Reset state, with requests pending while reset is held.
        repeat (2) @(posedge clock);
        #1;
        req_valid = '1;
        enable    = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_cordic_valid", cif.cordic_valid, 0);
        check("rst_cordic_code", cif.cordic_code, 0);
        check("rst_cordic_x", cif.cordic_x, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_x", res_x, 0);
        check("rst_err_bad_id", err_bad_id, 0);
        check("rst_err_overflow", err_overflow, 0);
        req_valid = '0;
        tick();
        reset_n = 1'b1;

        // Single request from requester 2.
        set_op(2, 16'h1000, 16'h0000, 16'h0648);
        req_valid = 4'b0100;
        res_ready = 4'hF;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check("single_issue_vld", cif.cordic_valid, 1);
        check("single_issue_code", cif.cordic_code, 8'h02);
        check("single_issue_x", cif.cordic_x, 16'h1000);
        check("single_issue_angle", cif.cordic_angle, 16'h0648);
        tick();
        check("single_one_pulse", cif.cordic_valid, 0);
        early = 1'b0;
        repeat (12) begin
            tick();
            if (res_valid != '0) early = 1'b1;
        end
        check("single_no_early_result", early, 0);
        tick();
        check("single_res_valid", res_valid, 4'b0100);
        check("single_res_x", res_x[2*W +: W], 16'h1000);
        check("single_res_y", res_y[2*W +: W], 16'h0648);
        tick();
        check("single_res_pulse_once", res_valid, 0);

        // Fairness: all four requesting; last grant was 2, so order is 3,0,1,2,...
        for (int r = 0; r < N; r++) set_op(r, 16'(16'h0100 * (r + 1)), 16'(16'h0010 * (r + 1)), 16'(r + 1));
        snap0     = pop_total();
        req_valid = 4'hF;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_id = (3 + i) % N;
            check("rr_grant", req_ready, 4'b0001 << exp_id);
            tick();
            check("rr_issue_vld", cif.cordic_valid, 1);
            check("rr_issue_code", cif.cordic_code, exp_id);
            check("rr_issue_x", cif.cordic_x, 16'(16'h0100 * (exp_id + 1)));
        end
        req_valid = '0;
        repeat (20) tick();
        check("rr_all_results_popped", pop_total() - snap0, 8);
        check("rr_drained", res_valid, 0);

        // Credit stall: requester 1 never pops, requester 0 keeps going.
        set_op(0, 16'h0A00, 16'h0000, 16'h0000);
        set_op(1, 16'h0B00, 16'h0000, 16'h0005);
        snap0     = acc_cnt[0];
        snap1     = acc_cnt[1];
        req_valid = 4'b0011;
        res_ready = 4'b1101;
        repeat (40) tick();
        check("stall_r1_accepts", acc_cnt[1] - snap1, 4);
        check("stall_r0_continues", (acc_cnt[0] - snap0) > 4, 1);
        check("stall_r1_ready_low", req_ready[1], 0);
        check("stall_r1_res_valid", res_valid[1], 1);
        check("stall_r1_head_x", res_x[1*W +: W], 16'h0B00);
        check("stall_no_overflow", err_overflow, 0);
        req_valid = 4'b0010;
        res_ready = 4'hF;
        #1;
        check("stall_pop_cycle_ready", req_ready, 0);
        tick();
        check("stall_grant_after_pop", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        repeat (25) tick();
        check("stall_drained", res_valid, 0);

        // Accept and pop together on requester 0 around the credit limit.
        set_op(0, 16'h0C00, 16'h0001, 16'h0002);
        req_valid = 4'b0001;
        res_ready = 4'b1110;
        repeat (4) tick();
        check("lim_r0_blocked", req_ready, 0);
        repeat (20) tick();
        check("lim_r0_full_fifo", res_valid, 4'b0001);
        check("lim_r0_head_x", res_x[0 +: W], 16'h0C00);
        check("lim_r0_head_y", res_y[0 +: W], 16'h0003);
        res_ready = 4'hF;
        #1;
        check("lim_c0_ready", req_ready, 0);
        tick();
        check("lim_c1_ready_with_pop", req_ready, 4'b0001);
        tick();
        res_ready = 4'b1110;
        #1;
        check("lim_c2_ready", req_ready, 4'b0001);
        tick();
        check("lim_c3_back_at_limit", req_ready, 0);
        req_valid = '0;
        res_ready = 4'hF;
        repeat (25) tick();
        check("lim_drained", res_valid, 0);
        check("lim_no_overflow", err_overflow, 0);

        // Bad code and FIFO overflow via the injection mux.
        res_ready = 4'b0111;
        inj_en    = 1'b1;
        inj_code  = 8'h07;
        inj_x     = 16'h1234;
        inj_y     = 16'h5678;
        tick();
        inj_en = 1'b0;
        check("bad_id_flag", err_bad_id, 1);
        check("bad_id_no_push", res_valid, 0);
        check("bad_id_no_overflow", err_overflow, 0);
        for (int i = 0; i < 4; i++) begin
            inj_en   = 1'b1;
            inj_code = 8'h03;
            inj_x    = 16'(16'h3000 + i);
            tick();
        end
        inj_en = 1'b0;
        check("ovf_fifo3_valid", res_valid, 4'b1000);
        check("ovf_fifo3_head", res_x[3*W +: W], 16'h3000);
        check("ovf_not_yet", err_overflow, 0);
        inj_en   = 1'b1;
        inj_x    = 16'h3FFF;
        tick();
        inj_en = 1'b0;
        check("ovf_flag", err_overflow, 1);
        check("ovf_head_kept", res_x[3*W +: W], 16'h3000);
        repeat (3) tick();
        check("bad_id_sticky", err_bad_id, 1);

        // Asynchronous reset mid-stream with results in flight.
        for (int r = 0; r < N; r++) set_op(r, 16'(16'h0200 * (r + 1)), 16'h0000, 16'h0000);
        req_valid = 4'b0111;
        repeat (10) tick();
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_cordic_valid", cif.cordic_valid, 0);
        check("arst_cordic_code", cif.cordic_code, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_res_x", res_x, 0);
        check("arst_err_bad_id", err_bad_id, 0);
        check("arst_err_overflow", err_overflow, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n   = 1'b1;
        req_valid = 4'hF;
        res_ready = 4'hF;
        #1;
        check("arst_first_grant_r0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        stale   = 1'b0;
        r0_seen = 0;
        repeat (20) begin
            tick();
            if (res_valid[3:1] != '0) stale = 1'b1;
            if (res_valid[0]) begin
                r0_seen++;
                check("arst_r0_result_x", res_x[0 +: W], 16'h0200);
            end
        end
        check("arst_no_stale", stale, 0);
        check("arst_r0_one_result", r0_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
